// File: rtl/fetch_unit.sv
// Instruction fetch unit: credit-limited request issue, in-order
// response buffer, and redirect flush with stale-response discard.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t        state;
  logic [31:0]   fetch_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard;
  logic [CW-1:0] count;
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [31:0]   buf_instr [DEPTH];
  logic [31:0]   buf_pc    [DEPTH];

  logic [CW:0]   used;
  logic          xfer;
  logic          nempty;
  logic          push;
  logic          pop;
  logic [31:0]   redir_pc;
  logic [31:0]   resp_pc;
  logic [CW-1:0] disc_fetch;
  logic [CW-1:0] disc_flush;

  // Credit covers both in-flight requests and buffered words,
  // so a response always has a free slot.
  assign used = {1'b0, outstanding} + {1'b0, count};
  assign imem_req_o  = (state == FETCH) && (used < DEPTH_C);
  assign imem_addr_o = fetch_pc;
  assign xfer = imem_req_o & imem_gnt_i;

  assign nempty = (count != '0);
  assign pop    = nempty & instr_ready_i;
  assign push   = (state == FETCH) & imem_rvalid_i
                & ~redirect_i;

  assign redir_pc = redirect_pc_i & 32'hFFFF_FFFC;

  // Oldest in-flight request sits 4*outstanding below fetch_pc.
  assign resp_pc = fetch_pc
                 - {{(30-CW){1'b0}}, outstanding, 2'b00};

  assign disc_fetch = outstanding + CW'(xfer)
                    - CW'(imem_rvalid_i);
  assign disc_flush = discard - CW'(imem_rvalid_i);

  assign instr_valid_o = nempty;
  assign instr_o = nempty ? buf_instr[rptr] : '0;
  assign pc_o    = nempty ? buf_pc[rptr]    : '0;

  // Control FSM: fetch address, in-flight and discard counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= BOOT;
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      unique case (state)
        BOOT: begin
          state <= FETCH;
          if (redirect_i) fetch_pc <= redir_pc;
        end
        FETCH: begin
          if (redirect_i) begin
            fetch_pc    <= redir_pc;
            outstanding <= '0;
            discard     <= disc_fetch;
            state <= (disc_fetch != '0) ? FLUSH : FETCH;
          end else begin
            if (xfer) fetch_pc <= fetch_pc + 32'd4;
            outstanding <= outstanding + CW'(xfer)
                         - CW'(imem_rvalid_i);
          end
        end
        FLUSH: begin
          if (redirect_i) fetch_pc <= redir_pc;
          discard <= disc_flush;
          if (disc_flush == '0) state <= FETCH;
        end
        default: state <= BOOT;
      endcase
    end
  end

  // Buffer occupancy and pointers; a redirect empties it.
  always_ff @(posedge clk) begin
    if (rst || redirect_i) begin
      count <= '0;
      wptr  <= '0;
      rptr  <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Buffer storage; contents are qualified by count.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      buf_instr[wptr] <= imem_rdata_i;
      buf_pc[wptr]    <= resp_pc;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, wrap-around and
// full-buffer sequences, then random traffic against a queue model.
module tb_fetch_unit;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, gnt, rvalid, redirect, valid, ready;
  logic [31:0] addr, rdata, rpc, instr, pc;
  logic        w_req, w_gnt, w_rvalid, w_redirect, w_valid, w_ready;
  logic [31:0] w_addr, w_rdata, w_rpc, w_instr, w_pc;

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req_o(req), .imem_addr_o(addr),
    .imem_gnt_i(gnt), .imem_rvalid_i(rvalid),
    .imem_rdata_i(rdata),
    .redirect_i(redirect), .redirect_pc_i(rpc),
    .instr_valid_o(valid), .instr_ready_i(ready),
    .instr_o(instr), .pc_o(pc)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(DEPTH)) u_wrap (
    .clk(clk), .rst(rst),
    .imem_req_o(w_req), .imem_addr_o(w_addr),
    .imem_gnt_i(w_gnt), .imem_rvalid_i(w_rvalid),
    .imem_rdata_i(w_rdata),
    .redirect_i(w_redirect), .redirect_pc_i(w_rpc),
    .instr_valid_o(w_valid), .instr_ready_i(w_ready),
    .instr_o(w_instr), .pc_o(w_pc)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit rst, gnt, rv;
    logic [31:0] rdata;
    bit rd;
    logic [31:0] rpc;
    bit rdy;
    bit e_req;
    logic [31:0] e_addr;
    bit e_vld;
    logic [31:0] e_instr, e_pc;
  } vec_t;

  vec_t tbl[$];

  task automatic v(input bit r, g, rv, input logic [31:0] d,
                   input bit rd, input logic [31:0] tp, input bit rdy,
                   input bit er, input logic [31:0] ea, input bit ev,
                   input logic [31:0] ei, ep);
    vec_t x;
    x.rst = r; x.gnt = g; x.rv = rv; x.rdata = d;
    x.rd = rd; x.rpc = tp; x.rdy = rdy;
    x.e_req = er; x.e_addr = ea; x.e_vld = ev;
    x.e_instr = ei; x.e_pc = ep;
    tbl.push_back(x);
  endtask

  // Reference model: bus-side request queue and delivery queue.
  typedef struct { logic [31:0] addr; bit stale; } mreq_t;
  typedef struct { logic [31:0] instr; logic [31:0] pc; } ent_t;
  mreq_t mq[$];
  ent_t  fq[$];
  bit    m_boot;
  logic [31:0] m_pc;

  function automatic bit m_req();
    bit st = 1'b0;
    foreach (mq[k]) if (mq[k].stale) st = 1'b1;
    return !m_boot && !st && (mq.size() + fq.size() < DEPTH);
  endfunction

  task automatic idle_inputs();
    gnt = 0; rvalid = 0; rdata = 0; redirect = 0; rpc = 0;
    ready = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    rst = 1'b0;
    mq.delete();
    fq.delete();
    m_boot = 1'b1;
    m_pc = 32'h0;
  endtask

  task automatic mcycle(input bit g, input bit rv_want,
                        input bit rdy, input bit rd,
                        input logic [31:0] tp, output bit xf);
    bit vld, rv;
    logic [31:0] d;
    mreq_t e;
    ent_t ne;
    chk("m_req", 32'(req), 32'(m_req()));
    chk("m_addr", addr, m_pc);
    vld = (fq.size() != 0);
    chk("m_valid", 32'(valid), 32'(vld));
    if (vld) begin
      chk("m_instr", instr, fq[0].instr);
      chk("m_pc", pc, fq[0].pc);
    end
    rv = rv_want && (mq.size() != 0);
    d = $urandom;
    gnt = g; rvalid = rv; rdata = d; ready = rdy;
    redirect = rd; rpc = tp;
    xf = req & g;
    tick();
    if (vld && rdy && !rd) void'(fq.pop_front());
    if (rv) begin
      e = mq.pop_front();
      if (!e.stale && !rd) begin
        ne.instr = d;
        ne.pc = e.addr;
        fq.push_back(ne);
      end
    end
    if (xf) begin
      e.addr = m_pc;
      e.stale = 1'b0;
      mq.push_back(e);
    end
    if (rd) begin
      fq.delete();
      foreach (mq[k]) mq[k].stale = 1'b1;
      m_pc = tp & 32'hFFFF_FFFC;
    end else if (xf) begin
      m_pc = m_pc + 32'd4;
    end
    m_boot = 1'b0;
  endtask

  localparam logic [31:0] I0 = 32'h1111_0001;
  localparam logic [31:0] I1 = 32'h2222_0002;
  localparam logic [31:0] I2 = 32'h3333_0003;
  localparam logic [31:0] JK = 32'hDEAD_BEEF;

  initial begin
    logic [31:0] wa[$];
    logic [31:0] wp[$];
    bit prev, xf;
    int gcnt;
    logic [31:0] tp;

    rst = 1'b1;
    idle_inputs();
    w_gnt = 0; w_rvalid = 0; w_rdata = 0; w_redirect = 0;
    w_rpc = 0; w_ready = 0;
    tick();

    // rst gnt rv rdata rd rpc rdy | req addr vld instr pc
    v(1,0,0,0 ,0,0,0,        0,32'h0,0,0,0);
    v(0,0,0,0 ,0,0,1,        0,32'h0,0,0,0);
    v(0,1,0,0 ,0,0,1,        1,32'h0,0,0,0);
    v(0,1,1,I0,0,0,1,        1,32'h4,0,0,0);
    v(0,1,1,I1,0,0,1,        0,32'h8,1,I0,32'h0);
    v(0,0,0,0 ,0,0,0,        1,32'h8,1,I1,32'h4);
    v(0,0,0,0 ,0,0,0,        1,32'h8,1,I1,32'h4);
    v(0,0,0,0 ,0,0,1,        1,32'h8,1,I1,32'h4);
    v(0,1,0,0 ,0,0,1,        1,32'h8,0,0,0);
    v(0,1,0,0 ,0,0,1,        1,32'hC,0,0,0);
    v(0,0,0,0 ,1,32'h1002,1, 0,32'h10,0,0,0);
    v(0,0,1,JK,0,0,1,        0,32'h1000,0,0,0);
    v(0,0,1,JK,0,0,1,        0,32'h1000,0,0,0);
    v(0,1,0,0 ,0,0,1,        1,32'h1000,0,0,0);
    v(0,0,1,I2,0,0,1,        1,32'h1004,0,0,0);
    v(0,1,0,0 ,0,0,0,        1,32'h1004,1,I2,32'h1000);
    v(0,0,1,JK,1,32'h2000,1, 0,32'h1008,1,I2,32'h1000);
    v(0,1,0,0 ,0,0,1,        1,32'h2000,0,0,0);
    v(1,0,0,0 ,0,0,1,        1,32'h2004,0,0,0);
    v(0,0,0,0 ,0,0,1,        0,32'h0,0,0,0);
    v(0,0,0,0 ,0,0,1,        1,32'h0,0,0,0);

    foreach (tbl[i]) begin
      chk($sformatf("row%0d req", i), 32'(req), 32'(tbl[i].e_req));
      chk($sformatf("row%0d addr", i), addr, tbl[i].e_addr);
      chk($sformatf("row%0d valid", i), 32'(valid),
          32'(tbl[i].e_vld));
      chk($sformatf("row%0d instr", i), instr, tbl[i].e_instr);
      chk($sformatf("row%0d pc", i), pc, tbl[i].e_pc);
      rst = tbl[i].rst; gnt = tbl[i].gnt; rvalid = tbl[i].rv;
      rdata = tbl[i].rdata; redirect = tbl[i].rd;
      rpc = tbl[i].rpc; ready = tbl[i].rdy;
      tick();
    end

    // Wrap-around from a high reset address.
    do_reset();
    w_gnt = 1; w_ready = 1;
    prev = 1'b0;
    for (int c = 0; c < 10; c++) begin
      w_rvalid = prev;
      w_rdata = 32'(c);
      if (w_req) wa.push_back(w_addr);
      if (w_valid) wp.push_back(w_pc);
      prev = w_req;
      tick();
    end
    w_gnt = 0; w_rvalid = 0;
    chk("wrap_nreq", 32'(wa.size() >= 3), 32'd1);
    if (wa.size() >= 3) begin
      chk("wrap_a0", wa[0], 32'hFFFF_FFF8);
      chk("wrap_a1", wa[1], 32'hFFFF_FFFC);
      chk("wrap_a2", wa[2], 32'h0000_0000);
    end
    chk("wrap_npc", 32'(wp.size() >= 2), 32'd1);
    if (wp.size() >= 2) begin
      chk("wrap_p0", wp[0], 32'hFFFF_FFF8);
      chk("wrap_p1", wp[1], 32'hFFFF_FFFC);
    end

    // Decode stalled: only DEPTH requests may issue.
    do_reset();
    gcnt = 0;
    for (int c = 0; c < 10; c++) begin
      mcycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, xf);
      gcnt += int'(xf);
    end
    chk("full_grants", 32'(gcnt), 32'(DEPTH));
    for (int c = 0; c < 8; c++)
      mcycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, xf);

    // Random traffic with redirects and occasional resets.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if (i % 1000 == 999) do_reset();
      tp = ($urandom_range(0, 1) == 0) ? $urandom
         : (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)));
      mcycle($urandom_range(0, 3) != 0,
             $urandom_range(0, 1) == 1,
             $urandom_range(0, 3) != 0,
             $urandom_range(0, 19) == 0,
             tp, xf);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
